// File: rtl/rv_hazard_ctrl_if.sv
// Pipeline-control bundle between the RV core stages and rv_hazard_ctrl.
// slave  : seen from the hazard controller
// master : seen from the pipeline stages (or a bench driving them)
interface rv_hazard_ctrl_if #(
   parameter int EXEC_STAGES = 1,
   parameter int BP_STAGES   = 3
) ();
   localparam int BPW = $clog2(BP_STAGES + 1);

   logic                       i_fetch_ack;
   logic [4:0]                 i_decode_rs1;
   logic [4:0]                 i_decode_rs2;
   logic                       i_decode_inv;
   logic [5*EXEC_STAGES-1:0]   i_exec_rd;
   logic [EXEC_STAGES-1:0]     i_exec_load;
   logic [4:0]                 i_exec_rs1;
   logic [4:0]                 i_exec_rs2;
   logic                       i_exec_pc_sel;
   logic                       i_mem_req;
   logic                       i_mem_ack;
   logic [5*BP_STAGES-1:0]     i_bp_rd;
   logic [BP_STAGES-1:0]       i_bp_we;
   logic [BPW-1:0]             o_exec_bp_rs1;
   logic [BPW-1:0]             o_exec_bp_rs2;
   logic                       o_fetch_stall;
   logic                       o_decode_stall;
   logic                       o_decode_flush;
   logic [EXEC_STAGES-1:0]     o_exec_flush;
   logic                       o_inv_instr;
   logic                       o_bus_err;

   modport slave (
      input  i_fetch_ack, i_decode_rs1, i_decode_rs2, i_decode_inv,
             i_exec_rd, i_exec_load, i_exec_rs1, i_exec_rs2, i_exec_pc_sel,
             i_mem_req, i_mem_ack, i_bp_rd, i_bp_we,
      output o_exec_bp_rs1, o_exec_bp_rs2, o_fetch_stall, o_decode_stall,
             o_decode_flush, o_exec_flush, o_inv_instr, o_bus_err
   );

   modport master (
      output i_fetch_ack, i_decode_rs1, i_decode_rs2, i_decode_inv,
             i_exec_rd, i_exec_load, i_exec_rs1, i_exec_rs2, i_exec_pc_sel,
             i_mem_req, i_mem_ack, i_bp_rd, i_bp_we,
      input  o_exec_bp_rs1, o_exec_bp_rs2, o_fetch_stall, o_decode_stall,
             o_decode_flush, o_exec_flush, o_inv_instr, o_bus_err
   );
endinterface

// File: rtl/rv_hazard_ctrl.sv
// RV core pipeline control: bypass select, load-use / multi-stage ALU
// interlock, flush generation, invalid-instruction trap and data-bus
// wait/timeout tracking. Only the reset counter, invalid pipe, traps and the
// bus FSM are registered; everything else is zero-latency combinational.
module rv_hazard_ctrl #(
   parameter int EXEC_STAGES = 1,
   parameter int BP_STAGES   = 3,
   parameter int RESET_FLUSH = 2,
   parameter int BUS_TIMEOUT = 15
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   rv_hazard_ctrl_if.slave     bus
);
   localparam int BPW = $clog2(BP_STAGES + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   logic [3:0]             rst_cnt;
   logic                   rst;
   logic [EXEC_STAGES-1:0] inv_pipe;
   logic                   inv_instr;
   logic                   bus_err;
   logic [1:0]             state;
   logic [7:0]             wait_cnt;
   logic [BPW-1:0]         bp_rs1;
   logic [BPW-1:0]         bp_rs2;
   logic                   hazard_raw;
   logic                   hazard;
   logic                   global_stall;
   logic                   decode_stall;
   logic                   decode_flush;
   logic [EXEC_STAGES-1:0] exec_flush;

   // Flush window: held during reset and for RESET_FLUSH cycles after release
   always_ff @(posedge i_clk) begin
      if (!i_reset_n)
         rst_cnt <= 4'(RESET_FLUSH);
      else if (rst_cnt != 4'd0)
         rst_cnt <= rst_cnt - 4'd1;
   end

   assign rst = !i_reset_n || (rst_cnt != 4'd0);

   // Bypass select: youngest matching writer wins, x0 always reads regfile
   always_comb begin
      bp_rs1 = '0;
      bp_rs2 = '0;
      for (int k = BP_STAGES - 1; k >= 0; k--) begin
         if (bus.i_exec_rs1 != 5'd0 && bus.i_bp_we[k] && bus.i_bp_rd[5*k +: 5] == bus.i_exec_rs1)
            bp_rs1 = BPW'(k + 1);
         if (bus.i_exec_rs2 != 5'd0 && bus.i_bp_we[k] && bus.i_bp_rd[5*k +: 5] == bus.i_exec_rs2)
            bp_rs2 = BPW'(k + 1);
      end
   end

   // Interlock: loads anywhere in exec, or ALU results not yet at the last stage
   always_comb begin
      hazard_raw = 1'b0;
      for (int j = 0; j < EXEC_STAGES; j++) begin
         if (bus.i_exec_rd[5*j +: 5] != 5'd0 &&
             (bus.i_exec_load[j] || j < EXEC_STAGES - 1) &&
             ((bus.i_decode_rs1 != 5'd0 && bus.i_decode_rs1 == bus.i_exec_rd[5*j +: 5]) ||
              (bus.i_decode_rs2 != 5'd0 && bus.i_decode_rs2 == bus.i_exec_rd[5*j +: 5])))
            hazard_raw = 1'b1;
      end
   end

   // A taken branch kills the decode instruction, so its hazard is moot
   assign hazard       = hazard_raw && !bus.i_exec_pc_sel;
   assign global_stall = inv_instr || bus_err || (state == ST_WAIT);
   assign decode_stall = global_stall || hazard || !bus.i_fetch_ack;
   assign decode_flush = rst || bus.i_exec_pc_sel || inv_instr;

   // Exec stage 0 takes a bubble whenever decode is held
   always_comb begin
      exec_flush    = {EXEC_STAGES{rst || bus.i_exec_pc_sel}};
      exec_flush[0] = exec_flush[0] || decode_stall;
   end

   // Invalid opcode travels alongside the instruction so a branch can cancel it
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         inv_pipe  <= '0;
         inv_instr <= 1'b0;
      end else begin
         inv_pipe[0] <= bus.i_decode_inv && !bus.i_exec_pc_sel && !decode_stall;
         for (int j = 1; j < EXEC_STAGES; j++)
            inv_pipe[j] <= inv_pipe[j-1] && !bus.i_exec_pc_sel;
         if (inv_pipe[EXEC_STAGES-1] && !decode_flush)
            inv_instr <= 1'b1;
      end
   end

   // Data-bus wait tracking; ack beats timeout, error is terminal until reset
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state    <= ST_IDLE;
         wait_cnt <= 8'd0;
         bus_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.i_mem_req) begin
                  state    <= ST_WAIT;
                  wait_cnt <= 8'd0;
               end
            end
            ST_WAIT: begin
               if (bus.i_mem_ack) begin
                  state <= ST_IDLE;
               end else if (wait_cnt == 8'(BUS_TIMEOUT - 1)) begin
                  state   <= ST_ERR;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= ST_ERR;
         endcase
      end
   end

   assign bus.o_exec_bp_rs1  = bp_rs1;
   assign bus.o_exec_bp_rs2  = bp_rs2;
   assign bus.o_fetch_stall  = rst || decode_stall;
   assign bus.o_decode_stall = decode_stall;
   assign bus.o_decode_flush = decode_flush;
   assign bus.o_exec_flush   = exec_flush;
   assign bus.o_inv_instr    = inv_instr;
   assign bus.o_bus_err      = bus_err;
endmodule
